// File: rtl/inst_fetch.sv
// Instruction-fetch initiator: owns the PC, drives a combinational instruction ROM,
// and buffers fetched {pc, inst} pairs in a small FIFO ahead of the decode stage.
module inst_fetch #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rom_ce_o,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_inst_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        out_valid_o,
    output logic [31:0] out_pc_o,
    output logic [31:0] out_inst_o,
    input  logic        id_ready_i
);

    localparam int          PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CNT_W     = $clog2(DEPTH + 1);
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    logic              ce;
    logic [31:0]       pc;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [31:0]       pc_mem   [DEPTH];
    logic [31:0]       inst_mem [DEPTH];

    logic pop;
    logic push;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop  = out_valid_o & id_ready_i;
    assign push = ce & ~redirect_i & ((count < CNT_W'(DEPTH)) | pop);

    assign rom_ce_o    = ce;
    assign rom_addr_o  = ce ? pc : ZERO_WORD;
    assign out_valid_o = (count != '0);
    assign out_pc_o    = out_valid_o ? pc_mem[rd_ptr]   : ZERO_WORD;
    assign out_inst_o  = out_valid_o ? inst_mem[rd_ptr] : ZERO_WORD;

    // Control state; a redirect wins over push/pop and empties the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ce     <= 1'b0;
            pc     <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            ce <= 1'b1;
            if (redirect_i) begin
                pc     <= redirect_pc_i & ~32'h0000_0003;
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    pc     <= pc + 32'd4;
                    wr_ptr <= ptr_next(wr_ptr);
                end
                if (pop) begin
                    rd_ptr <= ptr_next(rd_ptr);
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Entry storage needs no reset: it is only visible while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= pc;
            inst_mem[wr_ptr] <= rom_inst_i;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: cycle-by-cycle vector table over a word-indexed ROM
// model, plus a hand-written asynchronous reset pulse in the middle of a stream.
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        id_ready;

    int checks   = 0;
    int failures = 0;

    inst_fetch #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .rom_ce_o     (rom_ce),
        .rom_addr_o   (rom_addr),
        .rom_inst_i   (rom_inst),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .out_valid_o  (out_valid),
        .out_pc_o     (out_pc),
        .out_inst_o   (out_inst),
        .id_ready_i   (id_ready)
    );

    // ROM word i holds 32'h1000_0000 + i
    assign rom_inst = 32'h1000_0000 + {2'b00, rom_addr[31:2]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        redirect;
        logic [31:0] redirect_pc;
        logic        ready;
        logic        exp_ce;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic rd, input logic [31:0] rpc,
                                input logic rdy, input logic ce, input logic [31:0] addr,
                                input logic v, input logic [31:0] opc, input logic [31:0] oinst);
        vec_t t;
        t.rst = r; t.redirect = rd; t.redirect_pc = rpc; t.ready = rdy;
        t.exp_ce = ce; t.exp_addr = addr; t.exp_valid = v; t.exp_pc = opc; t.exp_inst = oinst;
        return t;
    endfunction

    task automatic check(input string name, input int row, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d got=%h expected=%h", name, row, act, exp);
        end
    endtask

    // One row = one clock cycle: drive inputs, check the cycle's outputs, then clock.
    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            rst         = vecs[i].rst;
            redirect    = vecs[i].redirect;
            redirect_pc = vecs[i].redirect_pc;
            id_ready    = vecs[i].ready;
            #1;
            check("rom_ce",    i, {31'd0, rom_ce},    {31'd0, vecs[i].exp_ce});
            check("rom_addr",  i, rom_addr,           vecs[i].exp_addr);
            check("out_valid", i, {31'd0, out_valid}, {31'd0, vecs[i].exp_valid});
            check("out_pc",    i, out_pc,             vecs[i].exp_pc);
            check("out_inst",  i, out_inst,           vecs[i].exp_inst);
            @(posedge clk);
            #1;
        end
    endtask

    int a_lo, a_hi, b_lo, b_hi, c_lo, c_hi;

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0;

        // Reset release, ready held high: 0,4,8,12 back to back
        a_lo = vecs.size();
        vecs.push_back(mk(1, 0, 0, 1, 0, 32'h0,  0, 32'h0,  32'h0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 32'h0,  0, 32'h0,  32'h0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'h0,  0, 32'h0,  32'h0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'h4,  1, 32'h0,  32'h1000_0000));
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'h8,  1, 32'h4,  32'h1000_0001));
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'hC,  1, 32'h8,  32'h1000_0002));
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'h10, 1, 32'hC,  32'h1000_0003));
        a_hi = vecs.size() - 1;

        // Backpressure, full pop+push, redirect with two queued, PC wrap
        b_lo = vecs.size();
        vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,  0, 32'h0,  32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,  0, 32'h0,  32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0,  0, 32'h0,  32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h4,  1, 32'h0,  32'h1000_0000));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h8,  1, 32'h0,  32'h1000_0000));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h8,  1, 32'h0,  32'h1000_0000));
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'h8,  1, 32'h0,  32'h1000_0000));
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'hC,  1, 32'h4,  32'h1000_0001));
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'h10, 1, 32'h8,  32'h1000_0002));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h14, 1, 32'hC,  32'h1000_0003));
        vecs.push_back(mk(0, 1, 32'h0000_0103, 0, 1, 32'h14, 1, 32'hC, 32'h1000_0003));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h100, 0, 32'h0,   32'h0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'h104, 1, 32'h100, 32'h1000_0040));
        vecs.push_back(mk(0, 1, 32'hFFFF_FFF8, 1, 1, 32'h108, 1, 32'h104, 32'h1000_0041));
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'hFFFF_FFF8, 0, 32'h0,         32'h0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFF8, 32'h4FFF_FFFE));
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'h0,         1, 32'hFFFF_FFFC, 32'h4FFF_FFFF));
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'h4,         1, 32'h0,         32'h1000_0000));
        b_hi = vecs.size() - 1;

        // Redirect while ce is still low: fetching begins at the redirect target
        c_lo = vecs.size();
        vecs.push_back(mk(1, 0, 0, 1, 0, 32'h0,   0, 32'h0,   32'h0));
        vecs.push_back(mk(0, 1, 32'h0000_0200, 1, 0, 32'h0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'h200, 0, 32'h0,   32'h0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'h204, 1, 32'h200, 32'h1000_0080));
        c_hi = vecs.size() - 1;

        repeat (2) @(posedge clk);
        #1;
        run_rows(a_lo, a_hi);

        // Mid-cycle reset pulse while a valid entry is at the head
        #2;
        rst = 1'b1;
        #1;
        check("async_rom_ce",    -1, {31'd0, rom_ce},    32'd0);
        check("async_rom_addr",  -1, rom_addr,           32'd0);
        check("async_out_valid", -1, {31'd0, out_valid}, 32'd0);
        check("async_out_pc",    -1, out_pc,             32'd0);
        check("async_out_inst",  -1, out_inst,           32'd0);
        @(posedge clk);
        #1;
        run_rows(a_lo, a_hi);

        run_rows(b_lo, b_hi);
        run_rows(c_lo, c_hi);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
